// File: rtl/dmem_dma_if.sv
// dmem_dma_if: control handshake and data-memory port bundle for dmem_dma.
// The fill/fill_value ports exist only when DMEM_DMA_FILL_EN is defined.
interface dmem_dma_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
);
    localparam int AW = $clog2(MEM_DEPTH);
    logic                  start;
    logic                  abort;
    logic [AW-1:0]         src;
    logic [AW-1:0]         dst;
    logic [AW:0]           len;
    logic                  busy;
    logic                  done;
    logic                  aborted;
    logic [AW:0]           words_done;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] dout;
`ifdef DMEM_DMA_FILL_EN
    logic                  fill;
    logic [DATA_WIDTH-1:0] fill_value;
    modport master (
        input  start, abort, src, dst, len, dout, fill, fill_value,
        output busy, done, aborted, words_done, addr, write_data, mem_write
    );
    modport slave (
        output start, abort, src, dst, len, dout, fill, fill_value,
        input  busy, done, aborted, words_done, addr, write_data, mem_write
    );
`else
    modport master (
        input  start, abort, src, dst, len, dout,
        output busy, done, aborted, words_done, addr, write_data, mem_write
    );
    modport slave (
        output start, abort, src, dst, len, dout,
        input  busy, done, aborted, words_done, addr, write_data, mem_write
    );
`endif
endinterface

// File: rtl/dmem_dma.sv
// dmem_dma: single-channel block-copy engine driving the data-memory port.
// Optional constant-fill mode (FL state) is compiled in with DMEM_DMA_FILL_EN.
module dmem_dma #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input logic        clk,
    input logic        RESET,
    dmem_dma_if.master bus
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [AW:0]   DEPTH = (AW+1)'(MEM_DEPTH);
    localparam logic [AW-1:0] LAST  = AW'(MEM_DEPTH - 1);
    typedef enum logic [2:0] {IDLE, RD, WR, FL, DONE} state_t;
    state_t                state, state_n;
    logic [AW-1:0]         cur_src, cur_dst;
    logic [AW:0]           remaining, words_done, len_sat;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  aborted_q, fill_sel, last, wr;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] a);
        return a == LAST ? '0 : a + 1'b1;
    endfunction

`ifdef DMEM_DMA_FILL_EN
    assign fill_sel = bus.fill;
`else
    assign fill_sel = 1'b0;
`endif
    assign len_sat = bus.len > DEPTH ? DEPTH : bus.len;
    assign last    = remaining == (AW+1)'(1);
    assign wr      = state == WR || state == FL;

    assign bus.busy       = state == RD || wr;
    assign bus.done       = state == DONE;
    assign bus.aborted    = aborted_q;
    assign bus.words_done = words_done;
    assign bus.mem_write  = wr;
    assign bus.addr       = state == RD ? cur_src : wr ? cur_dst : '0;
    assign bus.write_data = wr ? data_q : '0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = len_sat == '0 ? DONE : fill_sel ? FL : RD;
            RD:      state_n = bus.abort ? DONE : WR;
            WR:      state_n = bus.abort || last ? DONE : RD;
            FL:      state_n = bus.abort || last ? DONE : FL;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state      <= IDLE;
            cur_src    <= '0;
            cur_dst    <= '0;
            remaining  <= '0;
            words_done <= '0;
            data_q     <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (bus.start) begin
                    cur_src    <= bus.src;
                    cur_dst    <= bus.dst;
                    remaining  <= len_sat;
                    words_done <= '0;
                    aborted_q  <= 1'b0;
`ifdef DMEM_DMA_FILL_EN
                    if (bus.fill) data_q <= bus.fill_value;
`endif
                end
                RD: begin
                    data_q    <= bus.dout;
                    aborted_q <= bus.abort;
                end
                WR, FL: begin
                    words_done <= words_done + 1'b1;
                    cur_src    <= inc(cur_src);
                    cur_dst    <= inc(cur_dst);
                    remaining  <= remaining - 1'b1;
                    aborted_q  <= bus.abort;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_dma.sv
// tb_dmem_dma: table-driven and randomized checks of dmem_dma against a word-level copy model.
// Fill-mode checks are included when DMEM_DMA_FILL_EN is defined.
module tb_dmem_dma;
    localparam int D = 1024;
    logic clk = 0, RESET = 1;
    always #5 clk = ~clk;

    dmem_dma_if #(.DATA_WIDTH(32), .MEM_DEPTH(D)) bus();
    dmem_dma #(.DATA_WIDTH(32), .MEM_DEPTH(D)) dut (.clk(clk), .RESET(RESET), .bus(bus));

    logic [31:0] mem [D];
    logic [31:0] refm [D];
    logic        ld_en = 0;
    logic [9:0]  ld_a = 0;
    logic [31:0] ld_d = 0;
    assign bus.dout = mem[bus.addr];
    always @(posedge clk)
        if (bus.mem_write) mem[bus.addr] <= bus.write_data;
        else if (ld_en) mem[ld_a] <= ld_d;

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mem_chk(input string nm);
        int bad = 0;
        for (int i = 0; i < D; i++) if (mem[i] !== refm[i]) bad++;
        chk(nm, bad, 0);
    endtask

    // Reference: plain ascending word copy; abort at cycle k (RD if even, WR if odd) ends after k+1 edges
    task automatic ref_copy(input int s, input int d, input int l, input int ab,
                            output int w, output bit a, output int c);
        int n = l > D ? D : l;
        a = ab >= 0 && ab < 2 * n;
        w = a ? (ab + 1) / 2 : n;
        c = a ? ab + 1 : 2 * n;
        for (int i = 0; i < w; i++) refm[(d + i) % D] = refm[(s + i) % D];
    endtask

    task automatic run(input int s, input int d, input int l, input int ab, input bit poke,
                       output int w, output bit a, output int c, output int nw);
        bus.src = 10'(s); bus.dst = 10'(d); bus.len = 11'(l); bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0; nw = 0;
        for (c = 0; c < 3000 && !bus.done; c++) begin
            bus.abort = (c == ab);
            bus.start = poke;
            if (poke) begin
                bus.src = 10'($urandom); bus.dst = 10'($urandom); bus.len = 11'($urandom);
            end
            nw += int'(bus.mem_write);
            @(posedge clk); #1;
        end
        bus.abort = 0; bus.start = 0;
        chk("done_seen", bus.done, 1);
        w = int'(bus.words_done); a = bus.aborted;
        @(posedge clk); #1;
        chk("done_one_cycle", {bus.done, bus.busy, bus.mem_write}, 0);
        chk("words_done_hold", bus.words_done, w);
    endtask

    typedef struct {int src; int dst; int len; int ab; bit poke; int ew; bit ea; int ec;} vec_t;
    vec_t tbl[6];

    initial begin
        int w, c, nw, ew, ec, cnt;
        bit a, ea;
        logic [31:0] xw;
        tbl[0] = '{10,   100,  4,    -1, 0, 4,    0, 8};
        tbl[1] = '{200,  300,  0,    -1, 0, 0,    0, 0};
        tbl[2] = '{1022, 1023, 3,    -1, 0, 3,    0, 6};
        tbl[3] = '{50,   400,  8,    5,  1, 3,    1, 6};
        tbl[4] = '{60,   500,  5,    2,  0, 1,    1, 3};
        tbl[5] = '{0,    0,    1500, -1, 0, 1024, 0, 2048};
        bus.start = 0; bus.abort = 0; bus.src = 0; bus.dst = 0; bus.len = 0;
`ifdef DMEM_DMA_FILL_EN
        bus.fill = 0; bus.fill_value = 0;
`endif
        @(posedge clk); #1;
        for (int i = 0; i < D; i++) begin
            ld_en = 1; ld_a = 10'(i); ld_d = $urandom; refm[i] = ld_d;
            @(posedge clk); #1;
        end
        ld_en = 0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_aborted", bus.aborted, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_write_data", bus.write_data, 0);
        chk("rst_words_done", bus.words_done, 0);
        mem_chk("preload");
        RESET = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            xw = refm[tbl[i].src % D];
            ref_copy(tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].ab, ew, ea, ec);
            run(tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].ab, tbl[i].poke, w, a, c, nw);
            chk($sformatf("tbl%0d_words", i), w, tbl[i].ew);
            chk($sformatf("tbl%0d_aborted", i), a, tbl[i].ea);
            chk($sformatf("tbl%0d_cycles", i), c, tbl[i].ec);
            chk($sformatf("tbl%0d_writes", i), nw, tbl[i].ew);
            mem_chk($sformatf("tbl%0d_mem", i));
            if (i == 2) begin
                chk("wrap_1023", mem[1023], xw);
                chk("wrap_0", mem[0], xw);
                chk("wrap_1", mem[1], xw);
            end
        end

        // RESET during the second WR: that cycle's write still lands, nothing after it
        ref_copy(10, 900, 4, 3, ew, ea, ec);
        bus.src = 10; bus.dst = 900; bus.len = 4; bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_reset_in_wr", bus.mem_write, 1);
        RESET = 1;
        @(posedge clk); #1;
        RESET = 0;
        chk("reset_mem_write", bus.mem_write, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_words_done", bus.words_done, 0);
        cnt = 0;
        repeat (4) begin cnt += int'(bus.mem_write | bus.busy); @(posedge clk); #1; end
        chk("reset_quiet", cnt, 0);
        mem_chk("reset_mem");

        bus.abort = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.abort = 0;
        chk("idle_abort_ignored", {bus.busy, bus.done}, 0);

`ifdef DMEM_DMA_FILL_EN
        bus.fill = 1; bus.fill_value = 32'hDEADBEEF; bus.dst = 5; bus.len = 3; bus.start = 1;
        for (int i = 5; i < 8; i++) refm[i] = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.start = 0; bus.fill = 0;
        cnt = 0;
        repeat (3) begin cnt += int'(bus.mem_write); @(posedge clk); #1; end
        chk("fill_writes", cnt, 3);
        chk("fill_done", bus.done, 1);
        chk("fill_words", bus.words_done, 3);
        @(posedge clk); #1;
        mem_chk("fill_mem");
`endif

        for (int t = 0; t < 25; t++) begin
            int s, d, l, ab;
            bit pk;
            s = $urandom_range(0, D - 1);
            d = $urandom_range(0, D - 1);
            l = $urandom_range(0, 24);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * l + 1) : -1;
            pk = 1'($urandom_range(0, 1));
            ref_copy(s, d, l, ab, ew, ea, ec);
            run(s, d, l, ab, pk, w, a, c, nw);
            chk($sformatf("rnd%0d_words", t), w, ew);
            chk($sformatf("rnd%0d_aborted", t), a, ea);
            chk($sformatf("rnd%0d_cycles", t), c, ec);
            chk($sformatf("rnd%0d_writes", t), nw, ew);
            mem_chk($sformatf("rnd%0d_mem", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
